// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back path.
// Source ids double as the round-robin pointer encoding.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    function automatic src_e other_src(input src_e s);
        return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-source write-back arbiter: ALU vs load unit, round-robin or fixed priority.
// Grants are combinational from the requests and the registered pointer.
module wb_rr_arbiter
    import regfile_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_alu,
    input  logic req_mem,
    output logic gnt_alu,
    output logic gnt_mem
);

    src_e ptr_q;
    src_e ptr_d;
    src_e pref;
    logic contended;

    always_comb begin
        contended = req_alu && req_mem;
        pref      = RR_EN ? ptr_q : SRC_ALU;
        gnt_alu   = 1'b0;
        gnt_mem   = 1'b0;
        ptr_d     = ptr_q;
        // Nothing is accepted while reset is held, so no request is lost.
        if (!rst) begin
            if (contended) begin
                gnt_alu = (pref == SRC_ALU);
                gnt_mem = (pref == SRC_MEM);
                if (RR_EN) begin
                    ptr_d = other_src(pref);
                end
            end else begin
                gnt_alu = req_alu;
                gnt_mem = req_mem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= SRC_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler and hazard scoreboard feeding the register file write port.
// valid/ready: a transfer happens in any cycle where valid && ready; sources hold rd/data until then.
module regfile_wb_scheduler #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter bit RR_EN    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  logic [ADDR_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_ready,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rs,
    input  logic [ADDR_W-1:0]   issue_rt,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                issue_writes,
    output logic                issue_stall,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_rd,
    output logic [DATA_W-1:0]   wr_data,
    output logic [NUM_REGS-1:0] busy_mask
);

    import regfile_pkg::*;

    logic                gnt_alu;
    logic                gnt_mem;
    logic                wb_fire;
    logic [ADDR_W-1:0]   wb_rd;
    logic [DATA_W-1:0]   wb_data;
    logic                stall;
    logic                issue_fire;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                wr_en_q;
    logic                wr_en_d;
    logic [ADDR_W-1:0]   wr_rd_q;
    logic [ADDR_W-1:0]   wr_rd_d;
    logic [DATA_W-1:0]   wr_data_q;
    logic [DATA_W-1:0]   wr_data_d;

    wb_rr_arbiter #(
        .RR_EN(RR_EN)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_alu(alu_valid),
        .req_mem(mem_valid),
        .gnt_alu(gnt_alu),
        .gnt_mem(gnt_mem)
    );

    always_comb begin
        alu_ready = gnt_alu;
        mem_ready = gnt_mem;

        wb_fire = (alu_valid && gnt_alu) || (mem_valid && gnt_mem);
        wb_rd   = gnt_mem ? mem_rd   : alu_rd;
        wb_data = gnt_mem ? mem_data : alu_data;

        // Registered busy only: a register freed this cycle still blocks issue until next cycle.
        stall = !rst && issue_valid &&
                (busy_q[issue_rs] || busy_q[issue_rt] ||
                 (issue_writes && busy_q[issue_rd]));
        issue_stall = stall;
        issue_fire  = issue_valid && !stall && issue_writes && (issue_rd != REG_ZERO);

        busy_d = busy_q;
        if (wb_fire) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (issue_fire) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        // A write-back to r0 is consumed but never reaches the register file.
        wr_en_d   = wb_fire && (wb_rd != REG_ZERO);
        wr_rd_d   = wr_en_d ? wb_rd   : wr_rd_q;
        wr_data_d = wr_en_d ? wb_data : wr_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_rd_q   <= '0;
            wr_data_q <= '0;
        end else begin
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_rd     = wr_rd_q;
    assign wr_data   = wr_data_q;
    assign busy_mask = busy_q;

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Write-back scheduler and hazard scoreboard in front of the 32x32 register file's single write port.
- Arbitrates ALU and load-unit write-back requests onto the port (write enable, destination, data).
- Tracks per-register pending writes and stalls the issue stage on RAW/WAW hazards.
- Sits between the execute/memory stages and the register file; its registered outputs drive the register file's write control, destination and write-back data inputs directly.

Parameters:
- DATA_W, 32, write-back data width.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers (2**ADDR_W).
- RR_EN, 1, 1 = round-robin between sources; 0 = fixed priority, ALU always wins.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU write-back request.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- mem_valid  in  1  load-unit write-back request.
- mem_rd  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- mem_ready  out  1  load request accepted this cycle.
- issue_valid  in  1  instruction presented at issue.
- issue_rs  in  ADDR_W  first source register.
- issue_rt  in  ADDR_W  second source register.
- issue_rd  in  ADDR_W  destination register.
- issue_writes  in  1  instruction writes issue_rd.
- issue_stall  out  1  hazard; issue must hold.
- wr_en  out  1  register file write enable.
- wr_rd  out  ADDR_W  register file write address.
- wr_data  out  DATA_W  register file write data.
- busy_mask  out  NUM_REGS  pending-write bit per register (debug/verification).

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous, active-high.
- While rst is high:
  - wr_en=0, wr_rd=0, wr_data=0, busy_mask=0, grant pointer=ALU-first.
  - alu_ready=0, mem_ready=0, issue_stall=0.
- Reset mid-operation discards all pending state. Requests held across reset are accepted normally afterwards.

Handshake:
- valid/ready. A transfer occurs when valid && ready in the same cycle.
- Ready is combinational from valid and the grant pointer; at most one ready is high per cycle.
- Sources must hold valid, rd and data stable until accepted.

Arbitration:
- Exactly one request valid: that request is granted.
- Both valid: the pointer decides.
  - RR_EN=1: pointer toggles to the other source after each contended grant.
  - RR_EN=0: ALU always wins.
- No request: no grant, pointer unchanged.

Write port (latency 1):
- Accepted request with rd!=0: the next cycle shows wr_en=1, wr_rd=rd, wr_data=data.
- Otherwise the next cycle shows wr_en=0. wr_rd and wr_data hold their last value.
- Accepted request with rd==0: consumed, wr_en stays 0. Register 0 is never written.

Scoreboard:
- Set: busy[issue_rd] set at the clock edge when issue_valid && !issue_stall && issue_writes && issue_rd!=0.
- Clear: busy[rd] cleared at the clock edge of the accepted write-back transfer.
- busy[0] is always 0.
- Write-back to a non-busy register: still written, busy unchanged.
- issue_stall = issue_valid && (busy[issue_rs] || busy[issue_rt] || (issue_writes && busy[issue_rd])), using registered busy only.
- A register cleared this cycle still stalls issue this cycle. Issue proceeds the following cycle.
- Because a busy rd stalls issue, set and clear of the same register in one cycle cannot occur. A simultaneous set and clear on different registers both take effect.
- There is no counting: at most one outstanding writer per register.

Decomposition:
- Shared package regfile_pkg: DATA_W/ADDR_W/NUM_REGS constants, REG_ZERO=0, and source id enum SRC_ALU=0, SRC_MEM=1.
- One natural sub-module: wb_rr_arbiter (2-input round-robin grant plus pointer register, RR_EN honoured).
- Scoreboard and output registers live in the top module.

Test Plan:
- Reset behaviour: assert rst for 2 cycles with alu_valid=1 -> wr_en=0, busy_mask=0, alu_ready=0 throughout. The first cycle after release gives alu_ready=1.
- Single write and latency:
  - Issue rd=5, issue_writes=1 -> busy_mask=0x20.
  - Then ALU rd=5, data=0xDEADBEEF accepted -> next cycle wr_en=1, wr_rd=5, wr_data=0xDEADBEEF, busy_mask=0.
- Contention with RR_EN=1: both valid for 4 cycles (alu rd=1..4, mem rd=9..12) -> grants alternate ALU, MEM, ALU, MEM. wr_rd sequence is 1, 9, 2, 10, each one cycle after acceptance.
- RAW stall: busy r7; issue rs=7, rt=3 -> issue_stall=1.
  - mem_rd=7 accepted at cycle N -> stall remains 1 in cycle N, drops to 0 in cycle N+1.
- WAW stall and r0:
  - Busy r4; issue rd=4, issue_writes=1, sources r1/r2 -> issue_stall=1.
  - Issue rd=0, issue_writes=1 -> no stall, busy_mask unchanged.
  - ALU rd=0 accepted -> wr_en stays 0.
- Fixed priority with RR_EN=0: both valid for 3 cycles -> ALU granted all 3, mem_ready=0. MEM is granted in the cycle ALU deasserts valid.
